// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - wait-stated big-endian byte RAM controller with sized loads/stores
// Optional feature macro: MEM_ALIGN_TRAP_EN (misaligned accesses trap instead of being force-aligned)
module mem_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MFA,
  input  logic [5:0]        MOP,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Busy,
  output logic              MemTrap
);

  localparam logic [5:0] OP_LD   = 6'h00;
  localparam logic [5:0] OP_LDUB = 6'h01;
  localparam logic [5:0] OP_LDUH = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h04;
  localparam logic [5:0] OP_STB  = 6'h05;
  localparam logic [5:0] OP_STH  = 6'h06;
  localparam logic [5:0] OP_LDSB = 6'h09;
  localparam logic [5:0] OP_LDSH = 6'h0A;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [5:0]        mop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic [7:0]        mem [2**ADDR_W];

  logic              is_load, is_store, is_half, is_word;
  logic              access_ok;
  logic [ADDR_W-1:0] base, a1, a2, a3;
  logic [7:0]        rd0, rd1, rd2, rd3;
  logic [31:0]       load_val;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mop_q)
      OP_LD:            begin is_load = 1'b1; is_word = 1'b1; end
      OP_LDUB, OP_LDSB: is_load = 1'b1;
      OP_LDUH, OP_LDSH: begin is_load = 1'b1; is_half = 1'b1; end
      OP_ST:            begin is_store = 1'b1; is_word = 1'b1; end
      OP_STB:           is_store = 1'b1;
      OP_STH:           begin is_store = 1'b1; is_half = 1'b1; end
      default:          ;
    endcase
  end

`ifdef MEM_ALIGN_TRAP_EN
  logic misaligned;
  logic trap_q;

  assign misaligned = (is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));
  assign access_ok  = ~misaligned;
  assign base       = addr_q;
  assign MemTrap    = trap_q;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      trap_q <= 1'b0;
    end else if (state == S_ACCESS) begin
      trap_q <= misaligned;
    end else if (state == S_DONE && !MFA) begin
      trap_q <= 1'b0;
    end
  end
`else
  // Low address bits are silently dropped so every sized access stays aligned.
  assign access_ok = 1'b1;
  assign base      = is_word ? {addr_q[ADDR_W-1:2], 2'b00} :
                     is_half ? {addr_q[ADDR_W-1:1], 1'b0}  : addr_q;
  assign MemTrap   = 1'b0;
`endif

  assign a1  = base + ADDR_W'(1);
  assign a2  = base + ADDR_W'(2);
  assign a3  = base + ADDR_W'(3);
  assign rd0 = mem[base];
  assign rd1 = mem[a1];
  assign rd2 = mem[a2];
  assign rd3 = mem[a3];

  always_comb begin
    load_val = '0;
    case (mop_q)
      OP_LD:   load_val = {rd0, rd1, rd2, rd3};
      OP_LDUB: load_val = {24'b0, rd0};
      OP_LDSB: load_val = {{24{rd0[7]}}, rd0};
      OP_LDUH: load_val = {16'b0, rd0, rd1};
      OP_LDSH: load_val = {{16{rd0[7]}}, rd0, rd1};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (MFA) state_nx = S_WAIT;
      S_WAIT:   if (cnt == 4'd0) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_DONE;
      S_DONE:   if (!MFA) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      cnt     <= 4'd0;
      mop_q   <= 6'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      MFC     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MFA) begin
            mop_q  <= MOP;
            addr_q <= Address;
            din_q  <= DataIn;
            cnt    <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_ACCESS: begin
          MFC <= 1'b1;
          if (!access_ok)    DataOut <= 32'd0;
          else if (is_load)  DataOut <= load_val;
          else if (!is_store) DataOut <= 32'd0;
        end
        S_DONE: begin
          if (!MFA) MFC <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately outside reset; gating on Clr keeps an aborted transaction from writing.
  always_ff @(posedge Clk) begin
    if (Clr && state == S_ACCESS && access_ok && is_store) begin
      case (mop_q)
        OP_ST: begin
          mem[base] <= din_q[31:24];
          mem[a1]   <= din_q[23:16];
          mem[a2]   <= din_q[15:8];
          mem[a3]   <= din_q[7:0];
        end
        OP_STH: begin
          mem[base] <= din_q[15:8];
          mem[a1]   <= din_q[7:0];
        end
        default: mem[base] <= din_q[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl against a byte-array model
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int ADDR_W = 8;
  localparam int WAIT   = 2;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        mfa = 1'b0;
  logic [5:0]  mop = 6'd0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] data_out;
  logic        mfc, busy, mem_trap;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .Clk(clk), .Clr(clr_n), .MFA(mfa), .MOP(mop), .Address(addr), .DataIn(din),
    .DataOut(data_out), .MFC(mfc), .Busy(busy), .MemTrap(mem_trap)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_dout = 32'd0;
  logic        exp_trap = 1'b0;
  logic [5:0]  mop_pool [10] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0A, 6'h03, 6'h08};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: a sized big-endian access on a plain byte array.
  task automatic model_op(input logic [5:0] m, input logic [7:0] a, input logic [31:0] d);
    int size, ea;
    bit st, ld, sx;
    logic [31:0] v;
    size = 0; st = 0; ld = 0; sx = 0;
    exp_trap = 1'b0;
    case (m)
      6'h00: begin size = 4; ld = 1; end
      6'h01: begin size = 1; ld = 1; end
      6'h02: begin size = 2; ld = 1; end
      6'h04: begin size = 4; st = 1; end
      6'h05: begin size = 1; st = 1; end
      6'h06: begin size = 2; st = 1; end
      6'h09: begin size = 1; ld = 1; sx = 1; end
      6'h0A: begin size = 2; ld = 1; sx = 1; end
      default: ;
    endcase
    ea = int'(a);
    if (size > 1 && (ea % size) != 0) begin
`ifdef MEM_ALIGN_TRAP_EN
      exp_trap = 1'b1;
      exp_dout = 32'd0;
      return;
`else
      ea = ea - (ea % size);
`endif
    end
    if (st) begin
      for (int i = 0; i < size; i++) ref_mem[ea + i] = 8'(d >> (8 * (size - 1 - i)));
    end else if (ld) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = (v << 8) | 32'(ref_mem[ea + i]);
      if (sx && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      exp_dout = v;
    end else begin
      exp_dout = 32'd0;
    end
  endtask

  task automatic run_op(input logic [5:0] m, input logic [7:0] a, input logic [31:0] d, input int hold);
    int edges;
    bit busy_ok;
    logic [31:0] dout_seen;
    @(negedge clk);
    mop = m; addr = a; din = d; mfa = 1'b1;
    @(posedge clk);
    #1;
    mop = 6'($urandom); addr = 8'($urandom); din = $urandom;
    model_op(m, a, d);
    edges = 0;
    busy_ok = 1'b1;
    while (edges < 20) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (mfc) break;
      @(posedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(WAIT + 2));
    check("busy_during", 32'(busy_ok), 32'd1);
    check("dout", data_out, exp_dout);
    check("trap", 32'(mem_trap), 32'(exp_trap));
    dout_seen = data_out;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_mfc_busy", 32'({mfc, busy}), 32'd3);
      check("hold_dout", data_out, dout_seen);
    end
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk);
    #1;
    check("back_idle", 32'({mfc, busy, mem_trap}), 32'd0);
  endtask

  task automatic reset_mid(input logic [5:0] m, input logic [7:0] a, input logic [31:0] d, input int n);
    @(negedge clk);
    mop = m; addr = a; din = d; mfa = 1'b1;
    @(posedge clk);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    mfa = 1'b0;
    #1;
    check("rst_async_flags", 32'({mfc, busy, mem_trap}), 32'd0);
    check("rst_async_dout", data_out, 32'd0);
    exp_dout = 32'd0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_flags", 32'({mfc, busy, mem_trap}), 32'd0);
    check("reset_dout", data_out, 32'd0);
    clr_n = 1'b1;

    for (int w = 0; w < 64; w++) run_op(6'h04, 8'(w * 4), $urandom, 0);

    run_op(6'h04, 8'h10, 32'hA204_4012, 1);
    run_op(6'h00, 8'h10, 32'd0, 0);
    check("ld_0x10", data_out, 32'hA204_4012);

    run_op(6'h04, 8'h20, 32'd0, 0);
    run_op(6'h05, 8'h21, 32'h1234_56AB, 0);
    run_op(6'h01, 8'h21, 32'd0, 0);
    check("ldub_0x21", data_out, 32'h0000_00AB);
    run_op(6'h09, 8'h21, 32'd0, 0);
    check("ldsb_0x21", data_out, 32'hFFFF_FFAB);
    run_op(6'h00, 8'h20, 32'd0, 0);
    check("ld_0x20", data_out, 32'h00AB_0000);

    run_op(6'h06, 8'h32, 32'h0000_8001, 0);
    run_op(6'h0A, 8'h32, 32'd0, 0);
    check("ldsh_0x32", data_out, 32'hFFFF_8001);
    run_op(6'h02, 8'h32, 32'd0, 0);
    check("lduh_0x32", data_out, 32'h0000_8001);

    run_op(6'h04, 8'h00, 32'h1122_3344, 0);
    run_op(6'h00, 8'h02, 32'd0, 0);
`ifdef MEM_ALIGN_TRAP_EN
    check("ld_mis_dout", data_out, 32'd0);
`else
    check("ld_mis_dout", data_out, 32'h1122_3344);
`endif

    run_op(6'h04, 8'h40, 32'h5A5A_0F0F, 0);
    reset_mid(6'h04, 8'h40, 32'hDEAD_BEEF, 1);
    run_op(6'h00, 8'h40, 32'd0, 3);
    check("abort_no_write", data_out, 32'h5A5A_0F0F);

    reset_mid(6'h00, 8'h10, 32'd0, 4);
    run_op(6'h03, 8'h10, 32'hFFFF_FFFF, 0);
    check("unsupported_dout", data_out, 32'd0);

    for (int k = 0; k < 150; k++) begin
      run_op(mop_pool[$urandom_range(0, 9)], 8'($urandom), $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
